// File: rtl/somador_bcd_serial.sv
// somador_bcd_serial: digit-serial packed-BCD adder, one digit pair per clock, LSD first.
// Rev 1.0
`default_nettype none

module somador_bcd_serial #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic [4*NDIG-1:0] s,
    output logic              cout,
    output logic              busy,
    output logic              done,
    output logic              erro
);

    localparam int W  = 4 * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SOMA = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            c_q, c_d;
    logic            cout_q, cout_d;
    logic            done_q, done_d;
    logic            erro_q, erro_d;

    logic [4:0]      w_t;
    logic [4:0]      w_tadj;
    logic            w_gt9;
    logic [3:0]      w_dig;
    logic [W-1:0]    w_acc_next;
    logic            w_bad;
    logic            w_last;

    // Operands shift right each step, so the active digit pair always sits in bits [3:0].
    always_comb begin
        w_t    = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
        w_tadj = w_t + 5'd6;
        w_gt9  = (w_t > 5'd9);
        w_dig  = w_gt9 ? w_tadj[3:0] : w_t[3:0];

        w_acc_next          = acc_q >> 4;
        w_acc_next[W-1 -: 4] = w_dig;

        w_last = (cnt_q == CW'(NDIG - 1));

        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        erro_d  = erro_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    erro_d  = w_bad;
                    state_d = SOMA;
                end
            end
            SOMA: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                acc_d = w_acc_next;
                c_d   = w_gt9;
                cnt_d = cnt_q + CW'(1);
                if (w_last) begin
                    s_d     = w_acc_next;
                    cout_d  = w_gt9;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            erro_q  <= erro_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign done = done_q;
    assign erro = erro_q;
    assign busy = (state_q == SOMA);

endmodule

`default_nettype wire

// File: tb/tb_somador_bcd_serial.sv
// Directed self-checking bench for somador_bcd_serial (NDIG=4).
`default_nettype none

module tb_somador_bcd_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        cout;
    logic        busy;
    logic        done;
    logic        erro;

    int total;
    int passed;

    logic [15:0] cur_s;
    logic        cur_cout;

    somador_bcd_serial #(.NDIG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done),
        .erro  (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full operation with latency and hold checks; returns with start low, one cycle after done.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] es, input logic ec, input logic ee);
        a = va; b = vb; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_erro_e0"}, erro, ee);
        for (int i = 1; i < 4; i++) begin
            a = 16'h7777; b = 16'h2222;          // must not disturb the running op
            tick();
            chk({tag, "_done_early"}, done, 0);
            chk({tag, "_s_hold"}, s, cur_s);
            chk({tag, "_cout_hold"}, cout, cur_cout);
        end
        tick();                                   // E4
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_erro"}, erro, ee);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        cur_s = es; cur_cout = ec;
    endtask

    initial begin
        total = 0; passed = 0;
        cur_s = 16'h0; cur_cout = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_erro", erro, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", busy, 0);

        run_op("add1234", 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
        run_op("add9999_1", 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("add9999_9999", 16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0);

        // start re-asserted while busy must be ignored
        a = 16'h0102; b = 16'h0304; start = 1'b1;
        tick();                                   // E0
        a = 16'h1111; b = 16'h2222;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("ign_done_early", done, 0);
        end
        start = 1'b0;
        tick();                                   // E4
        chk("ign_done", done, 1);
        chk("ign_s", s, 16'h0406);
        chk("ign_cout", cout, 0);
        tick();
        chk("ign_done_once", done, 0);
        chk("ign_busy", busy, 0);
        tick();
        chk("ign_done_none", done, 0);
        cur_s = 16'h0406; cur_cout = 1'b0;

        run_op("bad_digit", 16'h00A0, 16'h0000, 16'h0100, 1'b0, 1'b1);
        run_op("after_bad", 16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0);

        // reset mid-operation
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick();                                   // E1
        tick();                                   // E2
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s", s, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_erro", erro, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_done", done, 0);
        end
        cur_s = 16'h0; cur_cout = 1'b0;
        run_op("post_rst", 16'h0007, 16'h0006, 16'h0013, 1'b0, 1'b0);

        // start held high: accept in every done cycle, period 5
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        tick();                                   // first E0
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("bb_done", done, ((k % 5) == 4) ? 1 : 0);
            if ((k % 5) == 4) chk("bb_s", s, 16'h0002);
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
